// File: rtl/mips_lsu_pkg.sv
// Shared definitions for the MIPS load/store unit: access-size encodings,
// FSM state type, and helpers for alignment checking and store lane merging.
package mips_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    DONE   = 2'd3
  } lsu_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = a[0];
      SZ_WORD: bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Replace the addressed little-endian lane of word with the low bits of wdata.
  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] size, input logic [1:0] a);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_BYTE: res[{a, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: res[{a[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_WORD: res = wdata;
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mips_lsu_extract.sv
// Load lane selection and sign/zero extension for the MIPS load/store unit.
module mips_lsu_extract
  import mips_lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  input  logic [1:0]  i_a,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane and widen it to a full word.
  always_comb begin
    w_byte = i_word[{i_a, 3'b000} +: 8];
    w_half = i_word[{i_a[1], 4'b0000} +: 16];
    case (i_size)
      SZ_BYTE: o_data = {{24{i_sext & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_sext & w_half[15]}}, w_half};
      SZ_WORD: o_data = i_word;
      default: o_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// MIPS load/store unit: byte/half/word core requests onto a word-only RAM,
// read-modify-write for sub-word stores. Optional counters under LSU_PERF_CNT_EN.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]       cnt_ld,
  output logic [31:0]       cnt_st,
  output logic [31:0]       cnt_err
`endif
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("mips_lsu: DATA_W must be 32");
  end

  lsu_state_t        r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_merge;
  logic              r_ready;
  logic              r_done;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              w_misaligned;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merged;

  assign w_misaligned = is_misaligned(r_size, r_addr[1:0]);
  assign w_merged     = lane_merge(r_merge, r_wdata, r_size, r_addr[1:0]);

  mips_lsu_extract u_extract (
    .i_word (ram_dout),
    .i_size (r_size),
    .i_sext (r_sext),
    .i_a    (r_addr[1:0]),
    .o_data (w_load_data)
  );

  assign ready    = r_ready;
  assign done     = r_done;
  assign err      = r_err;
  assign rdata    = r_rdata;
  assign ram_addr = {r_addr[ADDR_W-1:2], 2'b00};

  // Write strobe decoded from state so an async reset removes it immediately.
  always_comb begin
    case (r_state)
      ACCESS:  ram_we = r_we && (r_size == SZ_WORD) && !w_misaligned;
      MERGE:   ram_we = 1'b1;
      default: ram_we = 1'b0;
    endcase
  end

  // Write data: the merged word during read-modify-write, else the latched store data.
  always_comb begin
    if (r_state == MERGE) begin
      ram_din = w_merged;
    end else begin
      ram_din = r_wdata;
    end
  end

  // Main sequencer: accept, access, optional merge, completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_sext  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_merge <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_sext  <= req_sext;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_err   <= 1'b0;
            r_ready <= 1'b0;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_misaligned) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (!r_we) begin
            r_rdata <= w_load_data;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_size == SZ_WORD) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_merge <= ram_dout;
            r_state <= MERGE;
          end
        end
        MERGE: begin
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic [31:0] r_cnt_ld;
  logic [31:0] r_cnt_st;
  logic [31:0] r_cnt_err;

  assign cnt_ld  = r_cnt_ld;
  assign cnt_st  = r_cnt_st;
  assign cnt_err = r_cnt_err;

  // Completed-access counters; an erroring access counts only as an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_ld  <= 32'd0;
      r_cnt_st  <= 32'd0;
      r_cnt_err <= 32'd0;
    end else if (r_done) begin
      if (r_err) begin
        r_cnt_err <= r_cnt_err + 32'd1;
      end else if (r_we) begin
        r_cnt_st <= r_cnt_st + 32'd1;
      end else begin
        r_cnt_ld <= r_cnt_ld + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu: directed vector table, reset/back-to-back
// sequences and randomized accesses against a byte-array reference model.
module tb_mips_lsu;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] cnt_ld;
  logic [31:0] cnt_st;
  logic [31:0] cnt_err;
`endif

  mips_lsu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_sext  (req_sext),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ready     (ready),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
`ifdef LSU_PERF_CNT_EN
    ,
    .cnt_ld    (cnt_ld),
    .cnt_st    (cnt_st),
    .cnt_err   (cnt_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word RAM: combinational read, write on negedge.
  logic [31:0] mem [0:63];
  assign ram_dout = mem[ram_addr[7:2]];
  always @(negedge clk) begin
    if (ram_we) mem[ram_addr[7:2]] = ram_din;
  end

  // Reference model state: memory as plain bytes.
  logic [7:0] ref_bytes [0:255];
  logic [31:0] last_rd;
  int exp_ld, exp_st, exp_errc;
  int n_checks, n_err;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vecs [18];

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, got, exp);
    end
  endtask

  task automatic ram_init(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int k = 0; k < 4; k++) ref_bytes[4*w + k] = 8'(v >> (8*k));
  endtask

  function automatic logic model_bad(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
    int nb;
    int base;
    logic [31:0] v;
    nb = 1 << sz;
    base = int'(a[7:0]);
    v = 32'd0;
    for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[base + i]) << (8*i));
    if (sx && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
    return v;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = int'(a[7:2]) * 4;
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int nb;
    nb = 1 << sz;
    for (int i = 0; i < nb; i++) ref_bytes[int'(a[7:0]) + i] = 8'(wd >> (8*i));
  endtask

  // One access: drive at negedge, accept at posedge, then watch up to 8 cycles.
  task automatic do_access(input logic we, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] g_rd, output logic g_err, output int g_lat,
                           output int g_wm, output logic [31:0] g_din, output logic g_rdy);
    @(negedge clk);
    g_rdy = ready;
    req_we = we; req_size = sz; req_sext = sx; req_addr = a; req_wdata = wd; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    g_lat = 0; g_wm = 0; g_rd = 32'd0; g_err = 1'b0; g_din = 32'd0;
    for (int n = 1; n <= 8 && g_lat == 0; n++) begin
      @(negedge clk);
      if (ram_we) begin
        g_wm = g_wm | (1 << n);
        g_din = ram_din;
      end
      if (done) begin
        g_lat = n;
        g_rd = rdata;
        g_err = err;
      end
    end
  endtask

  task automatic run_check(input int idx, input logic we, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] g_rd, g_din;
    logic g_err, g_rdy, bad;
    int g_lat, g_wm, e_lat, e_wm;
    bad = model_bad(sz, a);
    do_access(we, sz, sx, a, wd, g_rd, g_err, g_lat, g_wm, g_din, g_rdy);
    e_lat = (exp_err || !we || sz == 2'd2) ? 2 : 3;
    e_wm  = (exp_err || !we) ? 0 : ((sz == 2'd2) ? 2 : 4);
    chk("ready", idx, {31'd0, g_rdy}, 32'd1);
    chk("latency", idx, 32'(g_lat), 32'(e_lat));
    chk("ram_we_cycles", idx, 32'(g_wm), 32'(e_wm));
    chk("rdata", idx, g_rd, exp_rd);
    chk("err", idx, {31'd0, g_err}, {31'd0, exp_err});
    if (we && !bad) begin
      model_store(sz, a, wd);
      chk("ram_din", idx, g_din, model_word(a));
    end
    if (bad) exp_errc++;
    else if (we) exp_st++;
    else exp_ld++;
  endtask

  initial begin
    int dn, rd;
    logic we, sx, bad;
    logic [1:0] sz;
    logic [31:0] a, wd, e_rd;
    n_checks = 0; n_err = 0;
    exp_ld = 0; exp_st = 0; exp_errc = 0;
    last_rd = 32'd0;
    rst_n = 1'b0; req = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sext = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int w = 0; w < 64; w++) ram_init(w, $urandom);
    ram_init(0, 32'h1fff_ffff);
    ram_init(1, 32'h1000_0002);
    ram_init(2, 32'h0000_0004);
    ram_init(30, 32'hffff_fff3);
    ram_init(40, 32'h1122_3344);

    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h00, 32'h0,         32'h1fff_ffff, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h07, 32'h0,         32'h0000_0010, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h78, 32'h0,         32'hffff_fff3, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h78, 32'h0,         32'h0000_00f3, 1'b0};
    vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h09, 32'h1234_56ab, 32'h0000_00f3, 1'b0};
    vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,         32'h0000_ab04, 1'b0};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h03, 32'h0000_1234, 32'h0000_ab04, 1'b1};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h02, 32'h0,         32'h0000_ab04, 1'b1};
    vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h7a, 32'h0,         32'hffff_ffff, 1'b0};
    vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h78, 32'h0,         32'h0000_fff3, 1'b0};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,         32'h0000_fff3, 1'b1};
    vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h02, 32'h0000_beef, 32'h0000_fff3, 1'b0};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h00, 32'h0,         32'hbeef_ffff, 1'b0};
    vecs[13] = '{1'b1, 2'd2, 1'b0, 32'h04, 32'hcafe_f00d, 32'hbeef_ffff, 1'b0};
    vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h04, 32'h0,         32'hcafe_f00d, 1'b0};
    vecs[15] = '{1'b0, 2'd1, 1'b1, 32'h06, 32'h0,         32'hffff_cafe, 1'b0};
    vecs[16] = '{1'b0, 2'd0, 1'b1, 32'h05, 32'h0,         32'hffff_fff0, 1'b0};
    vecs[17] = '{1'b0, 2'd0, 1'b0, 32'h06, 32'h0,         32'h0000_00fe, 1'b0};

    #12;
    chk("rst_ready", 0, {31'd0, ready}, 32'd1);
    chk("rst_done", 0, {31'd0, done}, 32'd0);
    chk("rst_err", 0, {31'd0, err}, 32'd0);
    chk("rst_rdata", 0, rdata, 32'd0);
    chk("rst_ram_we", 0, {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", 0, ram_addr, 32'd0);
    chk("rst_ram_din", 0, ram_din, 32'd0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_check(i, vecs[i].we, vecs[i].sz, vecs[i].sx, vecs[i].a, vecs[i].wd,
                vecs[i].exp_rd, vecs[i].exp_err);
      last_rd = vecs[i].exp_rd;
    end
    for (int w = 0; w < 64; w++) chk("mem_after_table", w, mem[w], model_word(32'(w * 4)));

    // Reset while an sh sits in MERGE: write strobe must vanish before the negedge.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd1; req_sext = 1'b0; req_addr = 32'ha2; req_wdata = 32'h0000_5555;
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #1;
    chk("merge_we", 0, {31'd0, ram_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_we", 0, {31'd0, ram_we}, 32'd0);
    chk("abort_ready", 0, {31'd0, ready}, 32'd1);
    chk("abort_done", 0, {31'd0, done}, 32'd0);
    chk("abort_rdata", 0, rdata, 32'd0);
    chk("abort_ram_addr", 0, ram_addr, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    chk("abort_mem", 0, mem[40], 32'h1122_3344);
    exp_ld = 0; exp_st = 0; exp_errc = 0; last_rd = 32'd0;
    run_check(100, 1'b0, 2'd2, 1'b0, 32'ha0, 32'h0, 32'h1122_3344, 1'b0);
    last_rd = 32'h1122_3344;

    // req held high: only IDLE cycles accept, so 9 cycles give 3 loads.
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_sext = 1'b0; req_addr = 32'h0; req = 1'b1;
    dn = 0; rd = 0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dn++;
      if (ready) rd++;
    end
    req = 1'b0;
    chk("held_done", 0, 32'(dn), 32'd3);
    chk("held_ready", 0, 32'(rd), 32'd3);
    exp_ld += 3;
    last_rd = model_word(32'h0);

    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 15) == 15) ? 2'd3 : 2'($urandom_range(0, 2));
      sx = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd = $urandom;
      bad = model_bad(sz, a);
      e_rd = (!we && !bad) ? model_load(sz, sx, a) : last_rd;
      run_check(200 + i, we, sz, sx, a, wd, e_rd, bad);
      last_rd = e_rd;
    end
    for (int w = 0; w < 64; w++) chk("mem_final", w, mem[w], model_word(32'(w * 4)));

`ifdef LSU_PERF_CNT_EN
    @(negedge clk);
    chk("cnt_ld", 0, cnt_ld, 32'(exp_ld));
    chk("cnt_st", 0, cnt_st, 32'(exp_st));
    chk("cnt_err", 0, cnt_err, 32'(exp_errc));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
